// File: rtl/testcard_gen_pkg.sv
// Shared types, colour constants and helpers for the test card generator.
package testcard_pkg;

    typedef enum logic [1:0] {
        TC_BARS   = 2'd0,
        TC_XHATCH = 2'd1,
        TC_CHECK  = 2'd2,
        TC_MOVE   = 2'd3
    } tc_mode_e;

    // RGB111 colour index: bit2 = R, bit1 = G, bit0 = B
    typedef logic [2:0] rgb111_t;

    localparam rgb111_t BLACK   = 3'b000;
    localparam rgb111_t BLUE    = 3'b001;
    localparam rgb111_t GREEN   = 3'b010;
    localparam rgb111_t CYAN    = 3'b011;
    localparam rgb111_t RED     = 3'b100;
    localparam rgb111_t MAGENTA = 3'b101;
    localparam rgb111_t YELLOW  = 3'b110;
    localparam rgb111_t WHITE   = 3'b111;

    // Widest channel expand111 can produce
    localparam int unsigned TC_MAX_CHAN_BITS = 16;

    // Counter width for a modulus; a modulus of 1 still needs one bit
    function automatic int unsigned cnt_width(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

    // Replicate each RGB111 bit across chanBits bits, packed {R,G,B} in the low bits
    function automatic logic [3*TC_MAX_CHAN_BITS-1:0] expand111(input rgb111_t idx,
                                                               input int unsigned chanBits);
        logic [3*TC_MAX_CHAN_BITS-1:0] res;
        logic [3*TC_MAX_CHAN_BITS-1:0] mask;
        rgb111_t                       t;
        res  = '0;
        mask = (48'(1) << chanBits) - 48'(1);
        t    = idx;
        for (int unsigned c = 0; c < 3; c++) begin
            res = res << chanBits;
            if (t[2]) begin
                res = res | mask;
            end
            t = t << 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/testcard_gen_if.sv
// Video timing in / pixel colour out bundle between timing generator and test card.
interface testcard_gen_if #(
    parameter int unsigned CHAN_BITS = 1
);
    logic [9:0]             pixelX;
    logic [9:0]             pixelY;
    logic                   displayEnable;
    logic                   fieldStart;
    logic [1:0]             mode;
    logic [3*CHAN_BITS-1:0] rgb;
    logic [1:0]             modeActive;

    modport master (
        output pixelX, pixelY, displayEnable, fieldStart, mode,
        input  rgb, modeActive
    );

    modport slave (
        input  pixelX, pixelY, displayEnable, fieldStart, mode,
        output rgb, modeActive
    );
endinterface

// File: rtl/testcard_gen_cell_counter.sv
// Modulo cell counter with a toggling cell bit; replaces divide/compare of pixel coordinates.
module tc_cell_counter
    import testcard_pkg::*;
#(
    parameter  int unsigned MOD = 45,
    localparam int unsigned CW  = cnt_width(MOD)
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          clear_i,
    input  logic          enable_i,
    output logic [CW-1:0] count_o,
    output logic          wrap_o,
    output logic          cell_o
);

    localparam logic [CW-1:0] LAST = CW'(MOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          cell_q, cell_d;

    // Next count/cell; outputs bypass the register on an enabled clock so the
    // value belonging to the current pixel/line is visible in the same cycle.
    always_comb begin
        wrap_o = enable_i && !clear_i && (cnt_q == LAST);
        cnt_d  = cnt_q + 1'b1;
        cell_d = cell_q;
        if (clear_i) begin
            cnt_d  = '0;
            cell_d = 1'b0;
        end else if (cnt_q == LAST) begin
            cnt_d  = '0;
            cell_d = ~cell_q;
        end
        count_o = enable_i ? cnt_d  : cnt_q;
        cell_o  = enable_i ? cell_d : cell_q;
    end

    // Count state advances only on enabled clocks
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cnt_q  <= '0;
            cell_q <= 1'b0;
        end else if (enable_i) begin
            cnt_q  <= cnt_d;
            cell_q <= cell_d;
        end
    end

endmodule

// File: rtl/testcard_gen.sv
// Multi-pattern PAL test card: bars, crosshatch, checker, moving bar; 2-clock pixel latency.
module testcard_gen
    import testcard_pkg::*;
#(
    parameter int unsigned CHAN_BITS = 1,
    parameter int unsigned ACTIVE_W  = 720,
    parameter int unsigned ACTIVE_H  = 288,
    parameter int unsigned NUM_BARS  = 8,
    parameter int unsigned GRID_X    = 45,
    parameter int unsigned GRID_Y    = 36,
    parameter int unsigned MOVE_W    = 32,
    parameter int unsigned MOVE_STEP = 4
) (
    input logic           clk,
    input logic           nReset,
    testcard_gen_if.slave vid
);

    localparam int unsigned BAR_W = ACTIVE_W / NUM_BARS;
    localparam int unsigned XW    = cnt_width(GRID_X);
    localparam int unsigned YW    = cnt_width(GRID_Y);
    localparam int unsigned BW    = cnt_width(BAR_W);
    localparam int unsigned IDX_W = (cnt_width(NUM_BARS) > 3) ? cnt_width(NUM_BARS) : 3;
    localparam logic [IDX_W-1:0] LAST_BAR = IDX_W'(NUM_BARS - 1);

    if (ACTIVE_W % NUM_BARS != 0) begin : g_bar_width_check
        $error("ACTIVE_W must be an integer multiple of NUM_BARS");
    end
    if (CHAN_BITS == 0 || CHAN_BITS > TC_MAX_CHAN_BITS) begin : g_chan_bits_check
        $error("CHAN_BITS out of range");
    end

    logic lineStart, fieldLine;
    assign lineStart = vid.displayEnable && (vid.pixelX == '0);
    assign fieldLine = lineStart && (vid.pixelY == '0);

    logic [XW-1:0] xCnt;
    logic [YW-1:0] yCnt;
    logic [BW-1:0] barCnt;
    logic          xCell, yCell, barCell;
    logic          xWrap, yWrap, barWrap;

    tc_cell_counter #(.MOD(GRID_X)) u_xcnt (
        .clk(clk), .nReset(nReset),
        .clear_i(lineStart), .enable_i(vid.displayEnable),
        .count_o(xCnt), .wrap_o(xWrap), .cell_o(xCell)
    );

    tc_cell_counter #(.MOD(GRID_Y)) u_ycnt (
        .clk(clk), .nReset(nReset),
        .clear_i(fieldLine), .enable_i(lineStart),
        .count_o(yCnt), .wrap_o(yWrap), .cell_o(yCell)
    );

    tc_cell_counter #(.MOD(BAR_W)) u_barcnt (
        .clk(clk), .nReset(nReset),
        .clear_i(lineStart), .enable_i(vid.displayEnable),
        .count_o(barCnt), .wrap_o(barWrap), .cell_o(barCell)
    );

    logic [IDX_W-1:0] barIdx_q, barIdx_d;
    tc_mode_e         modeActive_q, modeActive_d;
    logic [9:0]       movePos_q, movePos_d;
    logic [10:0]      moveSum;
    rgb111_t          idx_q, idx_d;
    logic [3*CHAN_BITS-1:0]        rgb_q, rgb_d;
    logic [3*TC_MAX_CHAN_BITS-1:0] rgbFull;

    // Bar index: cleared at line start, steps on each bar wrap, saturates at the last bar.
    // barIdx_d is also the current pixel's bar, as it only differs from barIdx_q on enabled clocks.
    always_comb begin
        barIdx_d = barIdx_q;
        if (lineStart) begin
            barIdx_d = '0;
        end else if (barWrap && (barIdx_q != LAST_BAR)) begin
            barIdx_d = barIdx_q + 1'b1;
        end
    end

    // Mode latch and moving-bar position, both updated only on fieldStart
    always_comb begin
        modeActive_d = modeActive_q;
        movePos_d    = movePos_q;
        moveSum      = {1'b0, movePos_q} + 11'(MOVE_STEP);
        if (vid.fieldStart) begin
            modeActive_d = tc_mode_e'(vid.mode);
            if (modeActive_q == TC_MOVE) begin
                movePos_d = (moveSum >= 11'(ACTIVE_W)) ? '0 : moveSum[9:0];
            end else begin
                movePos_d = '0;
            end
        end
    end

    // Stage 1: pattern colour index for the current pixel
    always_comb begin
        logic        pixValid;
        logic        xEdge, yEdge, inMove;
        logic [10:0] moveEnd;
        pixValid = vid.displayEnable && (vid.pixelX < 10'(ACTIVE_W)) && (vid.pixelY < 10'(ACTIVE_H));
        xEdge    = (vid.pixelX == 10'(ACTIVE_W - 1));
        yEdge    = (vid.pixelY == 10'(ACTIVE_H - 1));
        moveEnd  = {1'b0, movePos_q} + 11'(MOVE_W);
        inMove   = (vid.pixelX >= movePos_q) && ({1'b0, vid.pixelX} < moveEnd);
        idx_d    = BLACK;
        if (pixValid) begin
            case (modeActive_q)
                TC_BARS:   idx_d = barIdx_d[2:0];
                TC_XHATCH: idx_d = ((xCnt == '0) || (yCnt == '0) || xEdge || yEdge) ? WHITE : BLACK;
                TC_CHECK:  idx_d = (xCell ^ yCell) ? WHITE : BLACK;
                TC_MOVE:   idx_d = inMove ? WHITE : BLUE;
                default:   idx_d = BLACK;
            endcase
        end
    end

    // Stage 2: expand RGB111 to the output channel depth
    always_comb begin
        rgbFull = expand111(idx_q, CHAN_BITS);
        rgb_d   = rgbFull[3*CHAN_BITS-1:0];
    end

    // All pipeline and control state, asynchronously cleared to black / bars
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            barIdx_q     <= '0;
            modeActive_q <= TC_BARS;
            movePos_q    <= '0;
            idx_q        <= BLACK;
            rgb_q        <= '0;
        end else begin
            barIdx_q     <= barIdx_d;
            modeActive_q <= modeActive_d;
            movePos_q    <= movePos_d;
            idx_q        <= idx_d;
            rgb_q        <= rgb_d;
        end
    end

    assign vid.rgb        = rgb_q;
    assign vid.modeActive = modeActive_q;

    logic unused_sigs;
    assign unused_sigs = ^{rgbFull, barCnt, barCell, xWrap, yWrap};

endmodule
